// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master Wishbone arbiter (instruction/data) onto one shared bus
// One transfer per grant, round-robin on contention, optional bus timeout abort.
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic [31:0] iwbs_addr_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS_I = 2'd1, BUS_D = 2'd2} state_e;

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
  localparam bit         TimeoutEn    = (TIMEOUT_CYCLES != 0);

  state_e     state_q, state_d;
  logic       last_d_q, last_d_d;  // 1: data master held the most recent grant
  logic [7:0] cnt_q, cnt_d;

  logic i_req, d_req, busy, g_cyc, g_stb, resp, to_hit;

  assign i_req = iwbs_cyc_i && iwbs_stb_i;
  assign d_req = dwbs_cyc_i && dwbs_stb_i;
  assign resp  = wbm_ack_i || wbm_err_i;

  // Read data is broadcast; held at zero while reset is asserted.
  assign iwbs_dat_o = rst_ni ? wbm_dat_i : 32'h0;
  assign dwbs_dat_o = rst_ni ? wbm_dat_i : 32'h0;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    g_cyc      = 1'b0;
    g_stb      = 1'b0;
    to_hit     = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = 4'h0;
    wbm_addr_o = 32'h0;
    wbm_dat_o  = 32'h0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    timeout_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || !last_d_q)) begin
          state_d  = BUS_D;
          last_d_d = 1'b1;
          cnt_d    = 8'h0;
        end else if (i_req) begin
          state_d  = BUS_I;
          last_d_d = 1'b0;
          cnt_d    = 8'h0;
        end
      end
      BUS_I: begin
        busy       = 1'b1;
        g_cyc      = iwbs_cyc_i;
        g_stb      = iwbs_stb_i;
        wbm_sel_o  = 4'hF;
        wbm_addr_o = iwbs_addr_i;
      end
      BUS_D: begin
        busy       = 1'b1;
        g_cyc      = dwbs_cyc_i;
        g_stb      = dwbs_stb_i;
        wbm_we_o   = dwbs_we_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
      end
      default: state_d = IDLE;
    endcase

    if (busy) begin
      // A real response in the limit cycle takes precedence over the abort.
      to_hit     = TimeoutEn && (cnt_q == TimeoutLimit) && !resp;
      wbm_cyc_o  = g_cyc && !to_hit;
      wbm_stb_o  = g_stb && !to_hit;
      timeout_o  = to_hit;
      if (state_q == BUS_I) begin
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = wbm_err_i || to_hit;
      end else begin
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = wbm_err_i || to_hit;
      end
      if (resp || to_hit || !g_cyc) state_d = IDLE;
      else                          cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= 8'h0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] IADDR = 32'h0000_1F00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iwbs_cyc, iwbs_stb;
  logic [31:0] iwbs_addr;
  logic [31:0] iwbs_dat;
  logic        iwbs_ack, iwbs_err;
  logic        dwbs_cyc, dwbs_stb, dwbs_we;
  logic [3:0]  dwbs_sel;
  logic [31:0] dwbs_addr, dwbs_wdat;
  logic [31:0] dwbs_dat;
  logic        dwbs_ack, dwbs_err;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_addr, wbm_wdat;
  logic        wbm_ack, wbm_err;
  logic [31:0] wbm_rdat;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .iwbs_cyc_i(iwbs_cyc), .iwbs_stb_i(iwbs_stb), .iwbs_addr_i(iwbs_addr),
    .iwbs_dat_o(iwbs_dat), .iwbs_ack_o(iwbs_ack), .iwbs_err_o(iwbs_err),
    .dwbs_cyc_i(dwbs_cyc), .dwbs_stb_i(dwbs_stb), .dwbs_we_i(dwbs_we),
    .dwbs_sel_i(dwbs_sel), .dwbs_addr_i(dwbs_addr), .dwbs_dat_i(dwbs_wdat),
    .dwbs_dat_o(dwbs_dat), .dwbs_ack_o(dwbs_ack), .dwbs_err_o(dwbs_err),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
    .wbm_sel_o(wbm_sel), .wbm_addr_o(wbm_addr), .wbm_dat_o(wbm_wdat),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_dat_i(wbm_rdat),
    .timeout_o(timeout)
  );

  wire [70:0] wbm_v  = {wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_addr, wbm_wdat};
  wire [4:0]  resp_v = {iwbs_ack, iwbs_err, dwbs_ack, dwbs_err, timeout};
  wire [63:0] dat_v  = {iwbs_dat, dwbs_dat};

  typedef struct {
    logic       ic, is, dc, ds, ack, err;
    logic [1:0] gnt;   // 0 none, 1 instruction, 2 data
    logic       ecs;   // expected wbm_cyc_o and wbm_stb_o
    logic [4:0] eresp; // {iack, ierr, dack, derr, timeout}
  } row_t;

  row_t rows[23];

  task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Shared-bus request expected for a given owner, from the current inputs.
  function automatic logic [70:0] wbm_for(input int own, input logic c, input logic s);
    if (own == 1) return {c, s, 1'b0, 4'hF, iwbs_addr, 32'h0};
    if (own == 2) return {c, s, dwbs_we, dwbs_sel, dwbs_addr, dwbs_wdat};
    return '0;
  endfunction

  function automatic row_t mk(input logic [5:0] in, input logic [1:0] g, input logic ecs,
                              input logic [4:0] er);
    row_t r;
    {r.ic, r.is, r.dc, r.ds, r.ack, r.err} = in;
    r.gnt = g; r.ecs = ecs; r.eresp = er;
    return r;
  endfunction

  task automatic drive_idle();
    iwbs_cyc = 0; iwbs_stb = 0; dwbs_cyc = 0; dwbs_stb = 0; wbm_ack = 0; wbm_err = 0;
  endtask

  // Behavioural reference state: who owns the bus, who owned it last, cycles spent.
  int own, age;
  bit prev_data;

  initial begin
    iwbs_addr = IADDR; dwbs_we = 1; dwbs_sel = 4'b0011;
    dwbs_addr = 32'h8000_0010; dwbs_wdat = 32'hDEAD_BEEF; wbm_rdat = 32'h1234_5678;

    rows[0] = mk(6'b111100, 0, 0, 5'b00000);
    rows[1] = mk(6'b111100, 2, 1, 5'b00000);
    rows[2] = mk(6'b111100, 2, 1, 5'b00000);
    rows[3] = mk(6'b111110, 2, 1, 5'b00100);
    rows[4] = mk(6'b111100, 0, 0, 5'b00000);
    rows[5] = mk(6'b111111, 1, 1, 5'b11000);
    rows[6] = mk(6'b001110, 0, 0, 5'b00000);
    rows[7] = mk(6'b111100, 2, 1, 5'b00000);
    rows[8] = mk(6'b110000, 2, 0, 5'b00000);
    rows[9] = mk(6'b110000, 0, 0, 5'b00000);
    for (int k = 10; k <= 13; k++) rows[k] = mk(6'b110000, 1, 1, 5'b00000);
    rows[14] = mk(6'b110000, 1, 0, 5'b01001);
    rows[15] = mk(6'b000000, 0, 0, 5'b00000);
    rows[16] = mk(6'b110000, 0, 0, 5'b00000);
    for (int k = 17; k <= 20; k++) rows[k] = mk(6'b110000, 1, 1, 5'b00000);
    rows[21] = mk(6'b110010, 1, 1, 5'b10000);
    rows[22] = mk(6'b000000, 0, 0, 5'b00000);

    // Reset holds every output low even with requests and a bus response present.
    rst_n = 0;
    iwbs_cyc = 1; iwbs_stb = 1; dwbs_cyc = 1; dwbs_stb = 1; wbm_ack = 1; wbm_err = 1;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {wbm_v, resp_v, dat_v}, '0);
    end
    @(posedge clk); #1;
    rst_n = 1;

    for (int r = 0; r < 23; r++) begin
      {iwbs_cyc, iwbs_stb, dwbs_cyc, dwbs_stb, wbm_ack, wbm_err} =
        {rows[r].ic, rows[r].is, rows[r].dc, rows[r].ds, rows[r].ack, rows[r].err};
      @(negedge clk);
      check($sformatf("row%0d_wbm", r), wbm_v, wbm_for(rows[r].gnt, rows[r].ecs, rows[r].ecs));
      check($sformatf("row%0d_resp", r), resp_v, rows[r].eresp);
      check($sformatf("row%0d_dat", r), dat_v, {wbm_rdat, wbm_rdat});
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a data transfer.
    drive_idle();
    dwbs_cyc = 1; dwbs_stb = 1;
    @(posedge clk); #1;
    check("pre_reset_grant", wbm_v, wbm_for(2, 1, 1));
    #2 rst_n = 0;
    #1 check("reset_mid_xfer", {wbm_v, resp_v, dat_v}, '0);
    @(posedge clk); #1;
    rst_n = 1;
    drive_idle();
    wbm_ack = 1;
    @(negedge clk);
    check("late_ack_after_reset", {wbm_v, resp_v}, '0);
    @(posedge clk); #1;
    wbm_ack = 0;

    // Randomized traffic against the reference model (starts from a fresh reset).
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    own = 0; age = 0; prev_data = 0;
    for (int n = 0; n < 1500; n++) begin
      logic gc, gs, rsp, to;
      logic [70:0] ew;
      logic [4:0]  er;
      iwbs_cyc  = ($urandom % 4) != 0;
      iwbs_stb  = iwbs_cyc ? (($urandom % 4) != 0) : ($urandom % 8) == 0;
      dwbs_cyc  = ($urandom % 4) != 0;
      dwbs_stb  = dwbs_cyc ? (($urandom % 4) != 0) : ($urandom % 8) == 0;
      dwbs_we   = $urandom % 2;
      dwbs_sel  = 4'($urandom);
      iwbs_addr = $urandom;
      dwbs_addr = $urandom;
      dwbs_wdat = $urandom;
      wbm_rdat  = $urandom;
      wbm_ack   = ($urandom % 3) == 0;
      wbm_err   = ($urandom % 8) == 0;
      @(negedge clk);
      rsp = wbm_ack || wbm_err;
      gc  = (own == 1) ? iwbs_cyc : dwbs_cyc;
      gs  = (own == 1) ? iwbs_stb : dwbs_stb;
      to  = (own != 0) && (age == TO) && !rsp;
      ew  = wbm_for(own, gc && !to, gs && !to);
      if (own == 1)      er = {wbm_ack, wbm_err || to, 2'b00, to};
      else if (own == 2) er = {2'b00, wbm_ack, wbm_err || to, to};
      else               er = '0;
      check($sformatf("rnd%0d_wbm", n), wbm_v, ew);
      check($sformatf("rnd%0d_resp", n), resp_v, er);
      check($sformatf("rnd%0d_dat", n), dat_v, {wbm_rdat, wbm_rdat});
      @(posedge clk);
      if (own == 0) begin
        if ((iwbs_cyc && iwbs_stb) && (dwbs_cyc && dwbs_stb)) own = prev_data ? 1 : 2;
        else if (dwbs_cyc && dwbs_stb) own = 2;
        else if (iwbs_cyc && iwbs_stb) own = 1;
        if (own != 0) begin
          prev_data = (own == 2);
          age = 0;
        end
      end else if (rsp || to || !gc) begin
        own = 0;
      end else begin
        age++;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus cycles allowed without ack/err before abort; range 1..255, 0 disables.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iwbs_cyc_i  in  1  instruction master cycle.
REQ-005 SHALL have port iwbs_stb_i  in  1  instruction master strobe.
REQ-006 SHALL have port iwbs_addr_i  in  32  instruction fetch address.
REQ-007 SHALL have port iwbs_dat_o  out  32  read data to instruction master.
REQ-008 SHALL have port iwbs_ack_o  out  1  ack to instruction master.
REQ-009 SHALL have port iwbs_err_o  out  1  error to instruction master.
REQ-010 SHALL have ports dwbs_cyc_i, dwbs_stb_i, dwbs_we_i  in  1 each  data master cycle, strobe, write enable.
REQ-011 SHALL have port dwbs_sel_i  in  4  data master byte selects.
REQ-012 SHALL have ports dwbs_addr_i, dwbs_dat_i  in  32 each  data master address, write data.
REQ-013 SHALL have ports dwbs_dat_o  out  32; dwbs_ack_o, dwbs_err_o  out  1 each  responses to data master.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each; wbm_sel_o  out  4; wbm_addr_o, wbm_dat_o  out  32 each  shared bus request.
REQ-015 SHALL have ports wbm_ack_i, wbm_err_i  in  1 each; wbm_dat_i  in  32  shared bus response.
REQ-016 SHALL have port timeout_o  out  1  one-cycle pulse when a timeout abort occurs.

Function
REQ-017 SHALL implement FSM states IDLE, BUS_I, BUS_D.
REQ-018 IDLE: request = cyc_i&&stb_i; single requester -> its BUS_x next cycle; both -> master opposite to last_grant (round-robin bit); none -> stay.
REQ-019 last_grant SHALL update on every IDLE->BUS_x transition.
REQ-020 Arbitration latency SHALL be exactly 1 cycle: request visible in IDLE at edge N, wbm_cyc_o high from edge N.
REQ-021 In BUS_x, wbm_cyc_o/stb_o SHALL equal granted master's cyc_i/stb_i combinationally; wbm_we_o/sel_o/addr_o/dat_o from granted master; BUS_I drives we=0, sel=4'hF, dat=0.
REQ-022 In IDLE all wbm_* outputs SHALL be 0.
REQ-023 wbm_ack_i/wbm_err_i SHALL be routed only to granted master; ungranted master ack/err = 0; in IDLE both = 0 (late responses dropped).
REQ-024 iwbs_dat_o and dwbs_dat_o SHALL both equal wbm_dat_i (broadcast).
REQ-025 One transfer per grant: ack_i or err_i in BUS_x -> IDLE next cycle.
REQ-026 Master abort: granted cyc_i low in BUS_x -> wbm_cyc_o low same cycle, IDLE next cycle.
REQ-027 8-bit timeout counter SHALL clear on entry to BUS_x and increment each BUS_x cycle without ack/err.
REQ-028 When counter == TIMEOUT_CYCLES (nonzero) and no ack/err: err_o to granted master, timeout_o = 1, wbm_cyc_o/stb_o forced 0 that cycle, IDLE next cycle.
REQ-029 ack_i and timeout in same cycle: ack wins, no err, no timeout_o.
REQ-030 ack_i and err_i together: both forwarded unchanged to granted master.

Reset
REQ-031 rst_ni low SHALL asynchronously force IDLE, last_grant=BUS_I, counter=0; all outputs 0 while asserted, including mid-transfer.
REQ-032 First post-reset simultaneous request SHALL grant data master.

Verification
REQ-033 Both request at cycle 0 after reset -> BUS_D at cycle 1, ack at 3 -> dwbs_ack_o=1, iwbs_ack_o=0; IDLE at 4; BUS_I at 5.
REQ-034 Data store addr 0x8000_0010, sel 4'b0011, dat 0xDEAD_BEEF -> wbm_* carry same values, wbm_we_o=1, in BUS_D only.
REQ-035 TIMEOUT_CYCLES=4, instruction request never acked -> iwbs_err_o=1 and timeout_o=1 exactly once, 4 cycles after grant; IDLE next.
REQ-036 Granted dwbs_cyc_i dropped mid-cycle -> wbm_cyc_o=0 same cycle; pending iwbs request granted 1 cycle later.
REQ-037 rst_ni low during BUS_D -> all outputs 0 immediately; wbm_ack_i after release -> no master ack.
